ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, range 1..255: number of consecutive denied host-eligible cycles before the host is forced a grant over the CPU.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU data access request this cycle.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_stall  out  1  CPU access not granted this cycle; CPU holds its request.
- cpu_rdata  out  32  read data for a CPU read granted the previous cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- host_req  in  1  host request, level, held with stable fields until host_ack.
- host_we  in  1  1=write, 0=read.
- host_addr  in  32  host byte address.
- host_wdata  in  32  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  32  host read data, valid when host_ack=1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM synchronous read data, valid one cycle after address.
REQ-003 SHALL use one clock (clk); reset (rst) SHALL be synchronous and active-high.

Function
REQ-004 SHALL grant at most one requester per cycle; grant decision is combinational from current requests and registered state.
REQ-005 SHALL treat host as eligible when host_req=1 and host_ack=0 in the same cycle; no host grant in an ack cycle.
REQ-006 Priority: CPU wins when cpu_req=1, unless wait_cnt=STARVE_LIMIT and host eligible, then host wins.
REQ-007 wait_cnt: 8-bit register; +1 each cycle host eligible and not granted, saturating at STARVE_LIMIT; cleared on host grant or when host not eligible.
REQ-008 cpu_stall SHALL equal cpu_req AND NOT cpu_grant, same cycle, no registering.
REQ-009 Granted requester's addr/wdata SHALL drive ram_addr/ram_wdata; ram_we = granted we AND grant; with no grant ram_we=0, ram_addr/ram_wdata hold last driven value.
REQ-010 Owner FSM, registered, states IDLE, CPU, HOST = who was granted last cycle; next state = this cycle's grant (IDLE if none).
REQ-011 In state CPU after a read, cpu_rvalid=1 and cpu_rdata=ram_rdata; otherwise cpu_rvalid=0 and cpu_rdata=0.
REQ-012 In state HOST, host_ack=1; after a read host_rdata=ram_rdata captured and held in a register until next host ack; after a write host_rdata unchanged.
REQ-013 Latency: CPU granted read data 1 cycle after grant; host completion 1 cycle after grant; host throughput max 1 access per 2 cycles.
REQ-014 Simultaneous cpu_req and eligible host with wait_cnt<STARVE_LIMIT: CPU granted, host denied, wait_cnt increments.
REQ-015 Forced host grant: CPU stalled exactly that one cycle; CPU wins the next cycle (host in ack cycle).
REQ-016 Host deasserting host_req before ack is illegal; behaviour unspecified, no assertion requirement.

Reset
REQ-017 While rst=1: FSM=IDLE, wait_cnt=0, ram_we=0, cpu_stall=0, cpu_rvalid=0, cpu_rdata=0, host_ack=0, host_rdata=0, ram_addr=0, ram_wdata=0; no grants.
REQ-018 Reset mid-access SHALL abort any pending ack or rvalid; first grant possible in the first cycle with rst=0.

Verification
REQ-019 Idle: host_req=0; CPU read 0x10 then write 0xDEADBEEF to 0x14 -> cpu_stall=0 throughout, cpu_rvalid=1 next cycle with RAM data, ram_we=1 exactly one cycle.
REQ-020 Host-only: host read 0x40 (RAM holds 0x12345678) -> grant cycle N, host_ack=1 and host_rdata=0x12345678 at N+1, no grant at N+1, next grant earliest N+2.
REQ-021 Conflict: cpu_req=1 and host_req=1 same cycle, STARVE_LIMIT=8 -> CPU granted, cpu_stall=0, host waits.
REQ-022 Starvation: cpu_req=1 continuously, host_req=1 -> host granted at cycle 9 after eligibility, cpu_stall=1 only that cycle, host_ack next cycle, wait_cnt back to 0.
REQ-023 Reset mid-op: rst during a host read grant cycle -> host_ack=0 next cycle, all outputs at reset values, host retried and acked after release.
REQ-024 Write gating: stalled CPU write -> ram_we=0 while stalled, single ram_we=1 pulse once granted, RAM location updated once.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle for the CPU/host RAM arbiter: CPU port, host port and RAM port.
// The arbiter takes the slave view; the environment drives through master.
interface ram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;

  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  ram_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output host_ack, host_rdata,
    output ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output ram_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  host_ack, host_rdata,
    input  ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: CPU has priority, host is forced through after
// STARVE_LIMIT consecutive denied cycles. Owner FSM tracks last cycle's grant.
//
// state | meaning
// IDLE  | nothing granted last cycle
// CPU   | CPU granted last cycle (read data returns now if it was a read)
// HOST  | host granted last cycle (host_ack pulses now)
module ram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CPU, HOST} owner_t;

  owner_t      owner;
  logic        last_we;
  logic [7:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] host_rdata_q;

  logic        in_ack;
  logic        host_elig;
  logic        force_host;
  logic        host_grant;
  logic        cpu_grant;

  always_comb begin
    in_ack     = (owner == HOST);
    host_elig  = bus.host_req & ~in_ack;
    force_host = host_elig & (wait_cnt == LIMIT);
    host_grant = ~rst & host_elig & (~bus.cpu_req | force_host);
    cpu_grant  = ~rst & bus.cpu_req & ~host_grant;
  end

  // RAM port: granted requester drives combinationally so the synchronous
  // RAM sees the address in the grant cycle; otherwise the last value holds.
  always_comb begin
    bus.cpu_stall = ~rst & bus.cpu_req & ~cpu_grant;
    bus.ram_we    = (cpu_grant & bus.cpu_we) | (host_grant & bus.host_we);
    if (rst) begin
      bus.ram_addr  = 32'h0;
      bus.ram_wdata = 32'h0;
    end else if (cpu_grant) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
    end else if (host_grant) begin
      bus.ram_addr  = bus.host_addr;
      bus.ram_wdata = bus.host_wdata;
    end else begin
      bus.ram_addr  = addr_q;
      bus.ram_wdata = wdata_q;
    end
  end

  always_comb begin
    bus.cpu_rvalid = ~rst & (owner == CPU) & ~last_we;
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : 32'h0;
    bus.host_ack   = ~rst & in_ack;
    if (rst)
      bus.host_rdata = 32'h0;
    else if (in_ack & ~last_we)
      bus.host_rdata = bus.ram_rdata;
    else
      bus.host_rdata = host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= IDLE;
      last_we      <= 1'b0;
      wait_cnt     <= 8'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      host_rdata_q <= 32'h0;
    end else begin
      if (cpu_grant) begin
        owner   <= CPU;
        last_we <= bus.cpu_we;
      end else if (host_grant) begin
        owner   <= HOST;
        last_we <= bus.host_we;
      end else begin
        owner   <= IDLE;
        last_we <= 1'b0;
      end

      if (cpu_grant | host_grant) begin
        addr_q  <= bus.ram_addr;
        wdata_q <= bus.ram_wdata;
      end

      if (host_grant | ~host_elig)
        wait_cnt <= 8'd0;
      else if (wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 8'd1;

      if (in_ack & ~last_we)
        host_rdata_q <= bus.ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, shadow memory and read-data
// scoreboards for the CPU and host ports.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];
  logic        preload;
  logic [31:0] cpu_q  [$];
  logic [31:0] host_q [$];
  logic [31:0] host_hold;
  logic [31:0] exp_d;

  function automatic logic [31:0] pat(int i);
    if (i == 16) return 32'h1234_5678;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Synchronous-read RAM, read-before-write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      if (bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr[9:2]];
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Waits for the sampling edge and retires any returned read data.
  task automatic at_negedge;
    @(negedge clk);
    if (bus.cpu_rvalid === 1'b1) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_rvalid_unexpected got rvalid=1 rdata=%h required rvalid=0", bus.cpu_rdata);
      end else begin
        exp_d = cpu_q.pop_front();
        if (bus.cpu_rdata !== exp_d) begin
          errors++;
          $display("FAIL cpu_rdata got %h required %h", bus.cpu_rdata, exp_d);
        end
      end
    end else begin
      checks++;
      if (bus.cpu_rdata !== 32'h0) begin
        errors++;
        $display("FAIL cpu_rdata_idle got %h required 00000000", bus.cpu_rdata);
      end
    end
    if (bus.host_ack === 1'b1) begin
      checks++;
      if (host_q.size() == 0) begin
        errors++;
        $display("FAIL host_ack_unexpected got ack=1 required ack=0");
      end else begin
        exp_d = host_q.pop_front();
        if (bus.host_rdata !== exp_d) begin
          errors++;
          $display("FAIL host_rdata got %h required %h", bus.host_rdata, exp_d);
        end
      end
    end
  endtask

  task automatic drive_idle;
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 32'h0;
    bus.cpu_wdata  = 32'h0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 32'h0;
    bus.host_wdata = 32'h0;
  endtask

  task automatic cpu_read_back(input logic [31:0] addr);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = addr;
    at_negedge();
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL readback_stall got %b required 0", bus.cpu_stall);
    end
    cpu_q.push_back(shadow[addr[9:2]]);
    next_cycle();
    drive_idle();
    at_negedge();
    next_cycle();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    preload = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 32'h40; bus.host_wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      at_negedge();
      checks++;
      if ({bus.cpu_stall, bus.ram_we, bus.host_ack, bus.cpu_rvalid} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctrl got stall/we/ack/rvalid=%b required 0000",
                 {bus.cpu_stall, bus.ram_we, bus.host_ack, bus.cpu_rvalid});
      end
      checks++;
      if ({bus.ram_addr, bus.ram_wdata, bus.host_rdata} !== 96'h0) begin
        errors++;
        $display("FAIL reset_data got addr=%h wdata=%h hrdata=%h required 0",
                 bus.ram_addr, bus.ram_wdata, bus.host_rdata);
      end
      next_cycle();
    end
    checks++;
    if (dut.wait_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_wait_cnt got %0d required 0", dut.wait_cnt);
    end
    drive_idle();
    preload = 1'b0;
    host_hold = 32'h0;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_idle_cpu;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    at_negedge();
    checks++;
    if ({bus.cpu_stall, bus.ram_we} !== 2'b00 || bus.ram_addr !== 32'h10) begin
      errors++;
      $display("FAIL idle_read stall=%b we=%b addr=%h required 0 0 00000010",
               bus.cpu_stall, bus.ram_we, bus.ram_addr);
    end
    cpu_q.push_back(shadow[4]);
    next_cycle();
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h14; bus.cpu_wdata = 32'hDEAD_BEEF;
    at_negedge();
    checks++;
    if ({bus.cpu_stall, bus.ram_we} !== 2'b01 || bus.ram_addr !== 32'h14 ||
        bus.ram_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL idle_write stall=%b we=%b addr=%h wdata=%h required 0 1 00000014 deadbeef",
               bus.cpu_stall, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    shadow[5] = 32'hDEAD_BEEF;
    next_cycle();
    drive_idle();
    at_negedge();
    checks++;
    if (bus.ram_we !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.ram_addr !== 32'h14) begin
      errors++;
      $display("FAIL idle_after_write we=%b rvalid=%b addr=%h required 0 0 00000014",
               bus.ram_we, bus.cpu_rvalid, bus.ram_addr);
    end
    next_cycle();
    cpu_read_back(32'h14);
  endtask

  task automatic test_host_only;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h40;
    at_negedge();
    checks++;
    if (bus.ram_addr !== 32'h40 || bus.ram_we !== 1'b0 || bus.host_ack !== 1'b0) begin
      errors++;
      $display("FAIL host_grant addr=%h we=%b ack=%b required 00000040 0 0",
               bus.ram_addr, bus.ram_we, bus.host_ack);
    end
    host_q.push_back(shadow[16]);
    host_hold = shadow[16];
    next_cycle();
    at_negedge();
    checks++;
    if (bus.host_ack !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL host_ack_cycle ack=%b we=%b required 1 0", bus.host_ack, bus.ram_we);
    end
    next_cycle();
    bus.host_we = 1'b1; bus.host_addr = 32'h44; bus.host_wdata = 32'h0BAD_F00D;
    at_negedge();
    checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h44 || bus.host_ack !== 1'b0) begin
      errors++;
      $display("FAIL host_write_grant we=%b addr=%h ack=%b required 1 00000044 0",
               bus.ram_we, bus.ram_addr, bus.host_ack);
    end
    host_q.push_back(host_hold);
    shadow[17] = 32'h0BAD_F00D;
    next_cycle();
    at_negedge();
    checks++;
    if (bus.host_ack !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL host_no_regrant ack=%b we=%b required 1 0", bus.host_ack, bus.ram_we);
    end
    next_cycle();
    drive_idle();
    at_negedge();
    next_cycle();
    cpu_read_back(32'h44);
  endtask

  task automatic test_starvation;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 32'h80; bus.host_wdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 10; c++) begin
      at_negedge();
      checks++;
      if (bus.cpu_stall !== (c == 9)) begin
        errors++;
        $display("FAIL starve_stall cycle %0d got %b required %b", c, bus.cpu_stall, c == 9);
      end
      if (c == 9) begin
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h80 || bus.ram_wdata !== 32'hCAFE_F00D) begin
          errors++;
          $display("FAIL starve_host_grant we=%b addr=%h wdata=%h required 1 00000080 cafef00d",
                   bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        host_q.push_back(host_hold);
        shadow[32] = 32'hCAFE_F00D;
      end else begin
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h20) begin
          errors++;
          $display("FAIL starve_cpu_grant cycle %0d we=%b addr=%h required 0 00000020",
                   c, bus.ram_we, bus.ram_addr);
        end
        cpu_q.push_back(shadow[8]);
      end
      checks++;
      if (c <= 9 && dut.wait_cnt !== 8'(c - 1)) begin
        errors++;
        $display("FAIL starve_wait_cnt cycle %0d got %0d required %0d", c, dut.wait_cnt, c - 1);
      end else if (c == 10 && (dut.wait_cnt !== 8'd0 || bus.host_ack !== 1'b1)) begin
        errors++;
        $display("FAIL starve_after wait_cnt=%0d ack=%b required 0 1", dut.wait_cnt, bus.host_ack);
      end
      next_cycle();
    end
    drive_idle();
    at_negedge();
    next_cycle();
    cpu_read_back(32'h80);
  endtask

  task automatic test_write_gating;
    int we_pulses = 0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h84;
    for (int c = 1; c <= 11; c++) begin
      bus.cpu_req   = (c <= 10);
      bus.cpu_we    = (c >= 9);
      bus.cpu_addr  = (c >= 9) ? 32'h30 : 32'h24;
      bus.cpu_wdata = 32'h5555_AAAA;
      if (c == 11) bus.host_req = 1'b0;
      at_negedge();
      if (bus.ram_we === 1'b1 && bus.ram_addr === 32'h30) we_pulses++;
      if (c <= 8) cpu_q.push_back(shadow[9]);
      if (c == 9) begin
        checks++;
        if (bus.cpu_stall !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 32'h84) begin
          errors++;
          $display("FAIL gate_stalled stall=%b we=%b addr=%h required 1 0 00000084",
                   bus.cpu_stall, bus.ram_we, bus.ram_addr);
        end
        host_q.push_back(shadow[33]);
        host_hold = shadow[33];
      end
      if (c == 10) begin
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'h5555_AAAA) begin
          errors++;
          $display("FAIL gate_granted stall=%b we=%b wdata=%h required 0 1 5555aaaa",
                   bus.cpu_stall, bus.ram_we, bus.ram_wdata);
        end
        shadow[12] = 32'h5555_AAAA;
      end
      if (c == 11) begin
        checks++;
        if (bus.ram_we !== 1'b0) begin
          errors++; $display("FAIL gate_after we=%b required 0", bus.ram_we);
        end
      end
      next_cycle();
    end
    checks++;
    if (we_pulses != 1) begin
      errors++; $display("FAIL gate_pulses got %0d required 1", we_pulses);
    end
    drive_idle();
    cpu_read_back(32'h30);
  endtask

  task automatic test_reset_mid;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h40;
    at_negedge();
    checks++;
    if (bus.ram_addr !== 32'h40) begin
      errors++; $display("FAIL midrst_grant addr=%h required 00000040", bus.ram_addr);
    end
    rst = 1'b1;
    next_cycle();
    at_negedge();
    checks++;
    if ({bus.host_ack, bus.cpu_rvalid, bus.ram_we, bus.cpu_stall} !== 4'b0000 ||
        {bus.ram_addr, bus.ram_wdata, bus.host_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL midrst_outputs ack=%b rvalid=%b we=%b addr=%h hrdata=%h required all 0",
               bus.host_ack, bus.cpu_rvalid, bus.ram_we, bus.ram_addr, bus.host_rdata);
    end
    host_hold = 32'h0;
    next_cycle();
    rst = 1'b0;
    at_negedge();
    checks++;
    if (bus.ram_addr !== 32'h40 || bus.host_ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_retry addr=%h ack=%b required 00000040 0", bus.ram_addr, bus.host_ack);
    end
    host_q.push_back(shadow[16]);
    host_hold = shadow[16];
    next_cycle();
    at_negedge();
    checks++;
    if (bus.host_ack !== 1'b1) begin
      errors++; $display("FAIL midrst_ack got %b required 1", bus.host_ack);
    end
    next_cycle();
    drive_idle();
    at_negedge();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive_idle();
    test_reset();
    test_idle_cpu();
    test_host_only();
    test_starvation();
    test_write_gating();
    test_reset_mid();
    checks++;
    if (cpu_q.size() != 0 || host_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses cpu=%0d host=%0d required 0 0", cpu_q.size(), host_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
